// File: rtl/clk_divider_multi.sv
// Multi-channel programmable divider: each channel emits a registered square wave and a one-cycle tick per period.
// All outputs are registered with no input-to-output combinational path. Divisor updates wait for the end of the running period.
module clk_divider_multi #(
  parameter int WIDTH   = 25,
  parameter int NCH     = 4,
  parameter int CHW     = 2,
  parameter int DEF_DIV = 25000000
) (
  input  logic             clki,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic             cfg_we,
  input  logic [CHW-1:0]   cfg_ch,
  input  logic [WIDTH-1:0] cfg_div,
  output logic [NCH-1:0]   cfg_pend,
  output logic [NCH-1:0]   clko,
  output logic [NCH-1:0]   tick
);

  localparam logic [WIDTH-1:0] LP_DEF = WIDTH'(DEF_DIV);
  localparam logic [WIDTH-1:0] LP_ONE = WIDTH'(1);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_pdiv;
    logic [WIDTH-1:0] r_cnt;
    logic             r_pend;
    logic             r_clko;
    logic             r_tick;

    logic             w_wr;
    logic             w_stop;
    logic             w_wrap;
    logic             w_apply;
    logic [WIDTH-1:0] w_cnt_nxt;

    // Out-of-range channel indices never match any channel, so they are dropped here.
    assign w_wr      = cfg_we && (cfg_ch == CHW'(c));
    assign w_stop    = (r_div == '0);
    assign w_wrap    = !w_stop && (r_cnt == r_div - LP_ONE);
    assign w_apply   = r_pend && (sync || (en && (w_stop || w_wrap)));
    assign w_cnt_nxt = w_wrap ? '0 : r_cnt + LP_ONE;

    always_ff @(posedge clki) begin
      if (!rst_n) begin
        r_div  <= LP_DEF;
        r_pdiv <= LP_DEF;
        r_cnt  <= '0;
        r_pend <= 1'b0;
        r_clko <= 1'b0;
        r_tick <= 1'b0;
      end else begin
        // A write landing on the apply edge leaves the newer value pending.
        if (w_wr) begin
          r_pdiv <= cfg_div;
          r_pend <= 1'b1;
        end else if (w_apply) begin
          r_pend <= 1'b0;
        end

        if (w_apply) begin
          r_div <= r_pdiv;
        end

        if (sync) begin
          r_cnt  <= '0;
          r_clko <= 1'b0;
          r_tick <= 1'b0;
        end else if (en) begin
          if (w_apply) begin
            // New period starts at count 0; only N=1 is high from its first cycle.
            r_cnt  <= '0;
            r_clko <= (r_pdiv == LP_ONE);
            r_tick <= (r_pdiv != '0) && ((r_pdiv == LP_ONE) || w_wrap);
          end else if (w_stop) begin
            r_cnt  <= '0;
            r_clko <= 1'b0;
            r_tick <= 1'b0;
          end else begin
            r_cnt  <= w_cnt_nxt;
            r_clko <= (w_cnt_nxt >= (r_div >> 1));
            r_tick <= w_wrap;
          end
        end else begin
          r_tick <= 1'b0;
        end
      end
    end

    assign cfg_pend[c] = r_pend;
    assign clko[c]     = r_clko;
    assign tick[c]     = r_tick;
  end

endmodule

// File: doc/clk_divider_multi.md
Name: clk_divider_multi

Overview:
- Parametrised, multi-channel programmable clock divider and clock-enable generator.
- Each channel divides the system clock by a run-time divisor N and produces two outputs: a registered square wave (clko) and a one-cycle tick strobe.
- Successor to the fixed power-of-two divider. Adds programmable divisors, defined reset, global enable, phase sync, and glitch-free divisor updates.
- Sits at top level and feeds display multiplexing, keypad scanning and slow-logic enables.

Parameters:
- WIDTH, 25, width of divisor and counter per channel.
- NCH, 4, number of independent channels.
- CHW, 2, width of cfg_ch; must satisfy 2**CHW >= NCH.
- DEF_DIV, 25000000, divisor loaded into every channel at reset (must fit in WIDTH bits).

Ports:
- clki  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- en  input  1  global count enable; 0 freezes all channels.
- sync  input  1  single-cycle phase-align strobe for all channels.
- cfg_we  input  1  divisor write strobe.
- cfg_ch  input  CHW  channel index for the write.
- cfg_div  input  WIDTH  new divisor value.
- cfg_pend  output  NCH  per-channel flag: update written but not yet applied.
- clko  output  NCH  per-channel divided square wave, registered.
- tick  output  NCH  per-channel one-cycle strobe, once per period, registered.

Behaviour:
- Reset (rst_n=0 at a clki edge): div[c]=DEF_DIV, cnt[c]=0, pend[c]=0, cfg_pend=0, clko=0, tick=0 for all c. Reset overrides every other input.
- Per-channel state: div[c] (active), pdiv[c]/pend[c] (pending), cnt[c] (0..N-1).
- Channel modes by N = div[c]:
  - N=0: channel stopped. cnt=0, clko=0, tick=0.
  - N=1: tick=1 on every enabled cycle; clko held at 1.
  - N>=2: normal counting.
- Normal count, each edge with en=1:
  - if cnt==N-1: cnt_next=0 and tick<=1 (wrap).
  - otherwise: cnt_next=cnt+1 and tick<=0.
  - clko <= (cnt_next >= floor(N/2)).
  - Result: period N cycles; clko low for floor(N/2) cycles, high for ceil(N/2); tick coincides with the cycle clko falls.
- en=0: cnt and clko hold, tick<=0, pending updates wait.
- sync=1 (priority over en): all channels cnt<=0, clko<=0, tick<=0. Any pending value is applied immediately.
- Config write, when cfg_we=1 and cfg_ch<NCH: pdiv[cfg_ch]<=cfg_div and pend[cfg_ch]<=1.
  - cfg_ch>=NCH: write ignored.
  - Repeat write while pending: overwrites pdiv; last write wins.
- Apply point for a pending update: the next wrap edge (cnt==N-1, en=1), or the next edge if the current N<=1, or a sync edge.
  - On apply: div<=pdiv, cnt<=0, pend<=0, and clko/tick computed with the new N on that same edge.
  - The current period always completes, so clko never glitches.
- Write and apply in the same cycle, same channel: the apply uses the old pdiv. The new write stays pending (pend remains 1).
- sync and cfg_we in the same cycle: sync applies the existing pending value; the new write becomes pending.
- cfg_pend = pend vector, registered; it rises the edge after cfg_we.
- Counter arithmetic is unsigned WIDTH bits; cnt never exceeds N-1, so there is no overflow path.
- No combinational path from any input to any output.

Test Plan:
- Reset: DEF_DIV=4, hold rst_n=0 for 3 cycles, then en=1 -> clko, tick, cfg_pend all 0 during reset; each channel gives clko pattern 0,0,1,1 repeating, tick high once every 4 cycles, on the cycle clko falls.
- Odd divisor: write N=5 to ch1 -> after the current period ends, ch1 clko is 2 cycles low, 3 high; tick period 5; cfg_pend[1] high from the edge after the write until the apply edge.
- Mid-period update: ch0 at N=4, write N=10 when cnt=1 -> two further N=4 cycles complete, then N=10 starts with no short pulse; a second write of N=6 before apply -> 6 is applied, not 10.
- Edge divisors: N=0 on ch2 -> clko=0 and tick=0 indefinitely; N=1 on ch3 -> tick=1 every cycle and clko=1; then write N=2 -> applied on the next edge, clko toggles every cycle.
- en/sync: drop en for 7 cycles mid-period -> all outputs frozen and tick=0; pulse sync with a pending write on ch0 -> all cnt=0 and clko=0 the next cycle; the new N takes effect immediately and all channels are phase-aligned afterwards.
- Illegal channel and reset mid-run: cfg_ch=NCH write -> no cfg_pend change; assert rst_n=0 mid-period with a pending write -> div returns to DEF_DIV and the pending flag clears.
